// File: rtl/lstm_pkg.sv
// Shared Q5.26 constants and the h-gate FSM state type for the LSTM datapath.
package lstm_pkg;

    localparam int W     = 32;
    localparam int FRAC  = 26;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    localparam logic [W-1:0] ONE  = 32'h0400_0000;
    localparam logic [W-1:0] QMAX = 32'h7FFF_FFFF;
    localparam logic [W-1:0] QMIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OGWAIT,
        ST_SETTLE,
        ST_MUL,
        ST_WRITE,
        ST_ACK
    } hgate_state_t;

endpackage

// File: rtl/lstm_hgate_if.sv
// Bus between the tanh stage / output-gate source / buffer reader and lstm_hgate.
interface lstm_hgate_if;
    import lstm_pkg::*;

    // tanh_en/comp: level handshake; comp rises once the result is written and stays
    // high until tanh_en falls. og_valid/og_ready: og_ready pulses for the capture cycle.
    logic [W-1:0]  tanh_in;
    logic          tanh_en;
    logic          comp;
    logic [W-1:0]  og_in;
    logic          og_valid;
    logic          og_ready;
    logic [W-1:0]  h_out;
    logic          h_valid;
    logic [AW-1:0] h_idx;
    logic          frame_done;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;

    modport master (
        output tanh_in, tanh_en, og_in, og_valid, rd_addr,
        input  comp, og_ready, h_out, h_valid, h_idx, frame_done, rd_data
    );

    modport slave (
        input  tanh_in, tanh_en, og_in, og_valid, rd_addr,
        output comp, og_ready, h_out, h_valid, h_idx, frame_done, rd_data
    );

endinterface

// File: rtl/q526_mul_sat.sv
// Registered Q5.26 multiply with saturation back to Q5.26.
// HGATE_ROUND_EN selects round half-up; otherwise the product truncates toward -inf.
module q526_mul_sat
    import lstm_pkg::*;
(
    input  logic         clk,
    input  logic         i_load,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_res
);

    localparam logic [2*W-1:0] HALF = {{(2*W-1){1'b0}}, 1'b1} << (FRAC-1);

    logic signed [2*W-1:0] w_a;
    logic signed [2*W-1:0] w_b;
    logic signed [2*W-1:0] r_prod;
    logic [2*W-1:0]        w_adj;
    logic [W-FRAC:0]       w_top;

    assign w_a = {{W{i_a[W-1]}}, i_a};
    assign w_b = {{W{i_b[W-1]}}, i_b};

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_prod <= w_a * w_b;
        end
    end

`ifdef HGATE_ROUND_EN
    assign w_adj = r_prod + HALF;
`else
    assign w_adj = r_prod;
`endif

    // Everything above the kept sign bit must match it, else the result overflowed.
    assign w_top = w_adj[2*W-1:FRAC+W-1];

    always_comb begin
        o_res = w_adj[FRAC+W-1:FRAC];
        if (!((&w_top) || !(|w_top))) begin
            o_res = w_adj[2*W-1] ? QMIN : QMAX;
        end
    end

endmodule

// File: rtl/lstm_hgate.sv
// h = og * tanh(c) stage: pairs each tanh result with an output-gate value and fills
// a DEPTH-entry hidden-state buffer. Rounding mode selected by HGATE_ROUND_EN.
module lstm_hgate
    import lstm_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         locked,
    lstm_hgate_if.slave  bus,
    output hgate_state_t o_state
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH-1);

    hgate_state_t  r_state;
    logic [W-1:0]  r_og;
    logic [W-1:0]  r_tanh;
    logic [AW-1:0] r_wp;
    logic          r_comp;
    logic          r_og_ready;
    logic [W-1:0]  r_h_out;
    logic          r_h_valid;
    logic [AW-1:0] r_h_idx;
    logic          r_frame_done;
    logic [W-1:0]  r_rd_data;
    logic [W-1:0]  r_buf [DEPTH];

    logic          w_clr;
    logic          w_load;
    logic          w_wr;
    logic [W-1:0]  w_res;

    assign w_clr  = !rst || locked;
    assign w_load = (r_state == ST_MUL);
    assign w_wr   = !w_clr && (r_state == ST_WRITE);

    q526_mul_sat u_mul (
        .clk    (clk),
        .i_load (w_load),
        .i_a    (r_og),
        .i_b    (r_tanh),
        .o_res  (w_res)
    );

    // Buffer is deliberately not cleared by reset; reads see pre-write data.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[r_wp] <= w_res;
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state      <= ST_IDLE;
            r_og         <= '0;
            r_tanh       <= '0;
            r_wp         <= '0;
            r_comp       <= 1'b0;
            r_og_ready   <= 1'b0;
            r_h_out      <= '0;
            r_h_valid    <= 1'b0;
            r_h_idx      <= '0;
            r_frame_done <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_og_ready   <= 1'b0;
            r_h_valid    <= 1'b0;
            r_frame_done <= 1'b0;
            r_rd_data    <= r_buf[bus.rd_addr];
            case (r_state)
                ST_IDLE: begin
                    if (bus.tanh_en) r_state <= ST_OGWAIT;
                end
                ST_OGWAIT: begin
                    if (bus.og_valid) begin
                        r_og       <= bus.og_in;
                        r_og_ready <= 1'b1;
                        r_state    <= ST_SETTLE;
                    end
                end
                // tanh_en must still be high: the tanh sign correction lands a cycle late.
                ST_SETTLE: begin
                    if (bus.tanh_en) begin
                        r_tanh  <= bus.tanh_in;
                        r_state <= ST_MUL;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_h_out   <= w_res;
                    r_h_idx   <= r_wp;
                    r_h_valid <= 1'b1;
                    r_comp    <= 1'b1;
                    r_state   <= ST_ACK;
                end
                ST_ACK: begin
                    if (!bus.tanh_en) begin
                        r_comp       <= 1'b0;
                        r_frame_done <= (r_wp == LAST);
                        r_wp         <= (r_wp == LAST) ? '0 : r_wp + 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.comp       = r_comp;
    assign bus.og_ready   = r_og_ready;
    assign bus.h_out      = r_h_out;
    assign bus.h_valid    = r_h_valid;
    assign bus.h_idx      = r_h_idx;
    assign bus.frame_done = r_frame_done;
    assign bus.rd_data    = r_rd_data;
    assign o_state        = r_state;

endmodule
